// File: rtl/ids_pkg.sv
`timescale 1ns/1ps
// ids_pkg
// Shared types for the IDS trace sequencer: FSM state encoding, default
// address/data widths and the (expected, observed) sample pair carried
// through the pair FIFO.
package ids_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] e;
        logic [DEF_DATA_W-1:0] o;
    } pair_t;

endpackage

// File: rtl/ids_pair_fifo.sv
`timescale 1ns/1ps
// ids_pair_fifo
// Synchronous show-ahead FIFO of (expected, observed) pairs. The head entry
// is visible on 'head' whenever 'empty' is low; a pop consumes it at the
// next rising edge. Push and pop in the same cycle leave the count unchanged.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push        write push_data at the tail (ignored when full)
//   push_data   pair to write
//   pop         drop the head entry (ignored when empty)
//   head        current head entry
//   count       number of stored entries
//   empty       no entries stored
module ids_pair_fifo
    import ids_pkg::*;
#(
    parameter  int DEPTH = 3,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  pair_t            push_data,
    input  logic             pop,
    output pair_t            head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    pair_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ids_trace_sequencer.sv
`timescale 1ns/1ps
// ids_trace_sequencer
// Drives paired reads of the dual-port trace BRAM (port A = expected samples,
// port B = observed samples), absorbs the fixed BRAM read latency and hands
// aligned pairs to the IDS core over a valid/ready handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; base/len latched when start is accepted
// RUN   | issuing reads while data_rdy is high and FIFO credits remain
// DRAIN | all reads issued; waiting for in-flight reads and FIFO to empty
// FIN   | one-cycle done pulse, then back to IDLE
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, base_addr, len run request and its bounds
//   data_rdy              level enable for issuing reads
//   addra_out, addrb_out  BRAM port A/B addresses
//   douta_in, doutb_in    BRAM port A/B read data
//   e_out, o_out          head pair to the IDS core
//   pair_valid, pair_ready handshake with the IDS core
//   sample_idx            run-relative index of the pair on e_out/o_out
//   busy, done            run status
module ids_trace_sequencer
    import ids_pkg::*;
#(
    parameter int          ADDR_W   = DEF_ADDR_W,
    parameter int          DATA_W   = DEF_DATA_W,
    parameter int          RD_LAT   = 1,
    parameter int unsigned B_OFFSET = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              data_rdy,
    output logic [ADDR_W-1:0] addra_out,
    output logic [ADDR_W-1:0] addrb_out,
    input  logic [DATA_W-1:0] douta_in,
    input  logic [DATA_W-1:0] doutb_in,
    output logic [DATA_W-1:0] e_out,
    output logic [DATA_W-1:0] o_out,
    output logic              pair_valid,
    input  logic              pair_ready,
    output logic [ADDR_W:0]   sample_idx,
    output logic              busy,
    output logic              done
);

    localparam int FIFO_D = RD_LAT + 2;
    localparam int CNT_W  = $clog2(FIFO_D + 1);
    // Wide enough for fifo_count + inflight (at most 2*FIFO_D - 1).
    localparam int CR_W   = CNT_W + 1;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   issued;
    logic [ADDR_W-1:0] addra_next;
    logic [RD_LAT:0]   pipe;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    pair_t             fifo_head;
    pair_t             fifo_in;
    logic              accept_start;
    logic              issue;
    logic              push;
    logic              pop;
    logic [CR_W-1:0]   inflight;
    logic [CR_W-1:0]   committed;
    logic              credit_ok;

    assign accept_start = (state == IDLE) && start;
    assign addra_next   = base_r + issued[ADDR_W-1:0];
    assign push         = pipe[RD_LAT];
    assign pair_valid   = !fifo_empty;
    assign pop          = pair_valid && pair_ready;
    assign e_out        = fifo_head.e;
    assign o_out        = fifo_head.o;
    assign fifo_in      = '{e: douta_in, o: doutb_in};

    // A pair being popped this edge frees its slot in time for a read issued
    // on the same edge; without that, full-rate streaming would stall.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= RD_LAT; i++) begin
            inflight = inflight + CR_W'(pipe[i]);
        end
        committed = CR_W'(fifo_count) + inflight;
        credit_ok = (committed - CR_W'(pop)) < CR_W'(FIFO_D);
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (issued == len_r) begin
                    state_next = DRAIN;
                end else if (data_rdy && credit_ok) begin
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if ((pipe == '0) && fifo_empty) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            base_r     <= '0;
            len_r      <= '0;
            issued     <= '0;
            addra_out  <= '0;
            addrb_out  <= '0;
            pipe       <= '0;
            sample_idx <= '0;
        end else begin
            state <= state_next;
            // Tap RD_LAT of this shift register lines up with BRAM output data.
            pipe  <= {pipe[RD_LAT-1:0], issue};
            if (accept_start) begin
                base_r <= base_addr;
                len_r  <= len;
                issued <= '0;
            end else if (issue) begin
                issued    <= issued + (ADDR_W+1)'(1);
                addra_out <= addra_next;
                addrb_out <= addra_next + ADDR_W'(B_OFFSET);
            end
            if (accept_start) begin
                sample_idx <= '0;
            end else if (pop) begin
                sample_idx <= sample_idx + (ADDR_W+1)'(1);
            end
        end
    end

    ids_pair_fifo #(
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_in),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_ids_trace_sequencer.sv
`timescale 1ns/1ps
module tb_ids_trace_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [7:0]  base_addr;
    logic [8:0]  len;
    logic        data_rdy;
    logic        pair_ready;

    logic [7:0]  addra1, addrb1, addra2, addrb2;
    logic [15:0] douta1, doutb1, douta2, doutb2;
    logic [15:0] e1, o1, e2, o2;
    logic        pv1, pv2, busy1, busy2, done1, done2;
    logic [8:0]  idx1, idx2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ids_trace_sequencer #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .B_OFFSET(0)) dut1 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .data_rdy(data_rdy), .addra_out(addra1), .addrb_out(addrb1),
        .douta_in(douta1), .doutb_in(doutb1), .e_out(e1), .o_out(o1),
        .pair_valid(pv1), .pair_ready(pair_ready), .sample_idx(idx1),
        .busy(busy1), .done(done1)
    );

    ids_trace_sequencer #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3), .B_OFFSET(32'h80)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .base_addr(base_addr), .len(len),
        .data_rdy(data_rdy), .addra_out(addra2), .addrb_out(addrb2),
        .douta_in(douta2), .doutb_in(doutb2), .e_out(e2), .o_out(o2),
        .pair_valid(pv2), .pair_ready(pair_ready), .sample_idx(idx2),
        .busy(busy2), .done(done2)
    );

    // Behavioural BRAMs: A holds mem[i] = i, B holds i + 0x100.
    logic [15:0] a2_s1, a2_s2, b2_s1, b2_s2;
    always @(posedge clk) begin
        douta1 <= {8'h00, addra1};
        doutb1 <= 16'h0100 + {8'h00, addra1};
        a2_s1  <= {8'h00, addra2};
        b2_s1  <= 16'h0100 + {8'h00, addrb2};
        a2_s2  <= a2_s1;
        b2_s2  <= b2_s1;
        douta2 <= a2_s2;
        doutb2 <= b2_s2;
    end

    // Observation queues filled on the falling edge.
    logic [7:0]  a1_q[$], a2_q[$], b2_q[$];
    logic [15:0] e1_q[$], o1_q[$], e2_q[$], o2_q[$];
    logic [8:0]  i1_q[$];
    logic [7:0]  last_a1 = 8'h00, last_a2 = 8'h00;
    int          done_cnt1 = 0;
    int          max_out1 = 0;

    always @(negedge clk) begin
        if (addra1 != last_a1) begin
            if (!rst) a1_q.push_back(addra1);
            last_a1 = addra1;
        end
        if (addra2 != last_a2) begin
            if (!rst) begin
                a2_q.push_back(addra2);
                b2_q.push_back(addrb2);
            end
            last_a2 = addra2;
        end
        if (pv1 && pair_ready) begin
            e1_q.push_back(e1);
            o1_q.push_back(o1);
            i1_q.push_back(idx1);
        end
        if (pv2 && pair_ready) begin
            e2_q.push_back(e2);
            o2_q.push_back(o2);
        end
        if (done1) done_cnt1++;
        if (a1_q.size() - e1_q.size() > max_out1) max_out1 = a1_q.size() - e1_q.size();
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        a1_q.delete(); e1_q.delete(); o1_q.delete(); i1_q.delete();
        a2_q.delete(); b2_q.delete(); e2_q.delete(); o2_q.delete();
        max_out1 = 0;
    endtask

    task automatic kick(input logic [7:0] b, input logic [8:0] l);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done1(input string tag, input int budget, input bit bp);
        int c;
        c = 0;
        while (!done1 && c < budget) begin
            if (bp) pair_ready = ((c % 4) == 0) || ((c % 4) == 3);
            tick();
            c++;
        end
        check({tag, "_done_seen"}, done1, 1);
        check({tag, "_busy_at_done"}, busy1, 0);
        pair_ready = 1'b1;
        tick();
    endtask

    task automatic check_run(input string tag, input logic [7:0] b, input int n, input bit do_addr);
        logic [7:0] a;
        if (do_addr) check({tag, "_n_addr"}, a1_q.size(), n);
        check({tag, "_n_pairs"}, e1_q.size(), n);
        for (int i = 0; i < n; i++) begin
            a = b + 8'(i);
            if (do_addr && i < a1_q.size()) check({tag, "_addra"}, a1_q[i], a);
            if (i < e1_q.size()) begin
                check({tag, "_e"}, e1_q[i], {8'h00, a});
                check({tag, "_o"}, o1_q[i], 16'h0100 + {8'h00, a});
                check({tag, "_idx"}, i1_q[i], i);
            end
        end
    endtask

    initial begin
        int n;
        int d0;
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        base_addr = '0; len = '0; data_rdy = 1'b1; pair_ready = 1'b1;
        repeat (3) tick();
        check("rst_addra", addra1, 0);
        check("rst_addrb", addrb1, 0);
        check("rst_e", e1, 0);
        check("rst_o", o1, 0);
        check("rst_valid", pv1, 0);
        check("rst_idx", idx1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        rst = 1'b0;
        tick();
        clear_mon();

        // Basic run
        d0 = done_cnt1;
        kick(8'h10, 9'd4);
        check("basic_busy", busy1, 1);
        n = 0;
        while (!pv1 && n < 20) begin tick(); n++; end
        check("basic_latency", n, 3);
        wait_done1("basic", 40, 1'b0);
        check_run("basic", 8'h10, 4, 1'b1);
        check("basic_done_pulses", done_cnt1 - d0, 1);

        // Wrap-around
        clear_mon();
        kick(8'hFE, 9'd4);
        wait_done1("wrap", 40, 1'b0);
        check_run("wrap", 8'hFE, 4, 1'b1);

        // Backpressure
        clear_mon();
        kick(8'h20, 9'd8);
        wait_done1("bp", 100, 1'b1);
        check_run("bp", 8'h20, 8, 1'b1);
        check("bp_max_outstanding", max_out1, 3);

        // Pause after the 2nd issue
        clear_mon();
        kick(8'h40, 9'd6);
        tick();
        tick();
        data_rdy = 1'b0;
        check("pause_addra_2nd", addra1, 8'h41);
        repeat (5) tick();
        check("pause_addra_held", addra1, 8'h41);
        check("pause_inflight_out", e1_q.size(), 2);
        data_rdy = 1'b1;
        wait_done1("pause", 60, 1'b0);
        check_run("pause", 8'h40, 6, 1'b1);

        // Reset mid-run
        clear_mon();
        kick(8'h50, 9'd8);
        repeat (3) tick();
        check("mid_valid_pre", pv1, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_addra", addra1, 0);
        check("mid_rst_addrb", addrb1, 0);
        check("mid_rst_e", e1, 0);
        check("mid_rst_valid", pv1, 0);
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_done", done1, 0);
        tick();
        tick();
        rst = 1'b0;
        d0 = done_cnt1;
        clear_mon();
        repeat (6) tick();
        check("post_rst_pairs", e1_q.size(), 0);
        check("post_rst_done", done_cnt1 - d0, 0);
        check("post_rst_valid", pv1, 0);

        // Fresh run, plus a start while busy that must be ignored
        clear_mon();
        kick(8'h00, 9'd2);
        tick();
        kick(8'h70, 9'd3);
        wait_done1("restart", 40, 1'b0);
        check_run("restart", 8'h00, 2, 1'b0);
        repeat (6) tick();
        check("restart_done_pulses", done_cnt1 - d0, 1);
        check("restart_idle_busy", busy1, 0);

        // len = 0
        clear_mon();
        d0 = done_cnt1;
        kick(8'h99, 9'd0);
        check("len0_done", done1, 1);
        check("len0_busy", busy1, 0);
        tick();
        check("len0_done_fall", done1, 0);
        check("len0_addra", addra1, 8'h01);
        check("len0_no_issue", a1_q.size(), 0);
        check("len0_pulses", done_cnt1 - d0, 1);

        // Offset 0x80, RD_LAT = 3
        clear_mon();
        base_addr = 8'h10;
        len       = 9'd6;
        start2    = 1'b1;
        tick();
        start2    = 1'b0;
        n = 0;
        while (!pv2 && n < 20) begin tick(); n++; end
        check("lat3_latency", n, 5);
        n = 0;
        while (pv2 && n < 20) begin n++; tick(); end
        check("lat3_stream_len", n, 6);
        n = 0;
        while (!done2 && n < 30) begin tick(); n++; end
        check("lat3_done_seen", done2, 1);
        tick();
        check("lat3_n_addr", a2_q.size(), 6);
        check("lat3_n_pairs", e2_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < a2_q.size()) begin
                check("lat3_addra", a2_q[i], 8'h10 + 8'(i));
                check("lat3_addrb", b2_q[i], 8'h90 + 8'(i));
            end
            if (i < e2_q.size()) begin
                check("lat3_e", e2_q[i], 16'h0010 + 16'(i));
                check("lat3_o", o2_q[i], 16'h0190 + 16'(i));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
